logic_alu_stream: RTL

- Parametrised, registered successor to the team's fixed 16-bit bitwise gates.
- Applies one of six bitwise ops (AND, OR, XOR, NAND, NOR, XNOR) to operand pairs. Alternatively, reduces a stream of words with the chosen op.
- Valid/ready handshakes on input and output.
- Sits between the register file and the ALU datapath as a streaming logic coprocessor.

---
 rtl/logic_alu_stream.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/logic_alu_stream.sv
// Streaming bitwise logic unit: pairwise AND/OR/XOR/NAND/NOR/XNOR on operand
// pairs, or a left-fold reduction of a counted word stream, behind valid/ready.
module logic_alu_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_ones
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             out_valid_reg, out_valid_next;

  logic slot_free;
  logic ready_int;
  logic fire;
  logic first_is_long;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      default: r = x & y;
    endcase
    return r;
  endfunction

  assign slot_free     = !out_valid_reg || out_ready;
  // A reduce head with count>=2 only loads the accumulator, so it may enter
  // while an earlier result is still stalled in the output register.
  assign first_is_long = mode && (count > CNT_ONE);

  always_comb begin
    ready_int = 1'b0;
    if (!flush) begin
      if (state_reg == IDLE)
        ready_int = slot_free || first_is_long;
      else
        ready_int = (remaining_reg > CNT_ONE) ? 1'b1 : slot_free;
    end
  end

  assign fire = in_valid && ready_int;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    remaining_next = remaining_reg;
    op_next        = op_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;

    if (out_valid_reg && out_ready)
      out_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fire) begin
          if (!mode) begin
            out_next       = apply_op(op, in_a, in_b);
            out_valid_next = 1'b1;
          end else if (!first_is_long) begin
            out_next       = in_a;
            out_valid_next = 1'b1;
          end else begin
            acc_next       = in_a;
            remaining_next = count - CNT_ONE;
            op_next        = op;
            state_next     = ACC;
          end
        end
      end
      default: begin
        if (flush) begin
          acc_next       = '0;
          remaining_next = '0;
          state_next     = IDLE;
        end else if (fire) begin
          if (remaining_reg > CNT_ONE) begin
            acc_next       = apply_op(op_reg, acc_reg, in_a);
            remaining_next = remaining_reg - CNT_ONE;
          end else begin
            out_next       = apply_op(op_reg, acc_reg, in_a);
            out_valid_next = 1'b1;
            acc_next       = '0;
            remaining_next = '0;
            state_next     = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      op_reg        <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      remaining_reg <= remaining_next;
      op_reg        <= op_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign in_ready  = ready_int;
  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign out_zero  = (out_reg == '0);
  assign out_ones  = &out_reg;

endmodule
